// File: rtl/pong_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_comm_pkg
// Description : Shared definitions for the inter-board Pong link frame format.
//               Message type encoding, sync nibble, frame length and payload
//               bit positions used by both the sender and pong_msg_rx.
//               Frame length depends on PONG_RX_CHECKSUM_EN (5 bytes when
//               defined, 4 bytes otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
package pong_comm_pkg;

  typedef enum logic [1:0] {
    MSG_BALL     = 2'b00,
    MSG_MISS     = 2'b01,
    MSG_NEW_GAME = 2'b10,
    MSG_ACK      = 2'b11
  } msg_type_t;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam int         PAYLOAD_LEN = 3;

`ifdef PONG_RX_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  // Header byte layout: {sync[7:4], type[3:2], 2'b00}
  localparam int HDR_TYPE_LSB   = 2;
  // Ball payload: b1 = ball_y[7:0], b2[BALL_Y_HI_BIT] = ball_y[8], b3 = {vx, vy}
  localparam int BALL_Y_HI_BIT  = 0;
  localparam int VEL_X_LSB      = 4;
  localparam int VEL_Y_LSB      = 0;
  localparam int VEL_W          = 4;
  // Miss payload: b1/b2 low bits are scores, b3[SERVE_BIT] = you_should_serve
  // New-game payload: b1[SERVE_BIT] = you_serve_first
  localparam int SCORE_W        = 5;
  localparam int SERVE_BIT      = 0;

  function automatic logic is_header(input logic [7:0] b);
    return (b[7:4] == SYNC_NIBBLE) && (b[1:0] == 2'b00);
  endfunction

  function automatic msg_type_t header_type(input logic [7:0] b);
    return msg_type_t'(b[HDR_TYPE_LSB +: 2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_rx
// Description : 8N1 UART byte receiver, LSB first. Two-flop synchronizer on
//               the raw line, start-bit qualification at half bit, data and
//               stop sampled at bit centres.
// Ports       : clock, reset (async, active-high)
//               uart_rxd   - raw serial line, idle high
//               byte_data  - last received byte (valid with byte_valid)
//               byte_valid - one-cycle pulse, stop bit was 1
//               frame_err  - one-cycle pulse, stop bit was 0 (byte discarded)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t        state, state_n;
  logic             rxd_meta, rxd_sync, rxd_prev;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             valid_n, err_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rxd_prev && !rxd_sync) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        // A line that is high again at half bit was a glitch, not a start.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shift_n   = {rxd_sync, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        // Return to idle at mid stop bit so a back-to-back start edge is seen.
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          valid_n = rxd_sync;
          err_n   = ~rxd_sync;
          state_n = RX_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_meta   <= uart_rxd;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  // The shift register is untouched during the stop bit, so it holds the
  // complete byte while byte_valid pulses.
  assign byte_data = shift;

endmodule
`default_nettype wire

// File: rtl/pong_msg_rx.sv
`default_nettype none
// ============================================================================
// Module      : pong_msg_rx
// Description : Pong link receive path. Assembles UART bytes into fixed-length
//               frames, decodes ball / miss / new-game / ack messages and
//               presents them through a new_message_received / message_acked
//               handshake. A frame completing while a message is pending is
//               dropped and sets the sticky overrun flag.
//               Build option PONG_RX_CHECKSUM_EN: 5-byte frames whose last
//               byte is the XOR of bytes 0-3; mismatching frames are dropped.
// Ports       : clock, reset (async, active-high), uart_rxd (raw line),
//               message_acked (consumer took message);
//               new_message_received, one-hot type flags, ball_y_rx[8:0],
//               velocity_x_rx[3:0], velocity_y_rx[3:0] (signed),
//               my_score_rx[4:0], your_score_rx[4:0], you_should_serve_rx,
//               you_serve_first_rx, overrun (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module pong_msg_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rxd,
  input  logic       message_acked,
  output logic       new_message_received,
  output logic       ball_message_rx,
  output logic       miss_message_rx,
  output logic       new_game_message_rx,
  output logic       new_game_ack_message_rx,
  output logic [8:0] ball_y_rx,
  output logic [3:0] velocity_x_rx,
  output logic [3:0] velocity_y_rx,
  output logic [4:0] my_score_rx,
  output logic [4:0] your_score_rx,
  output logic       you_should_serve_rx,
  output logic       you_serve_first_rx,
  output logic       overrun
);

  import pong_comm_pkg::*;

  localparam int              CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int              TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int              TO_W         = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0] TO_ONE       = TO_W'(1);
  localparam logic [1:0]      LAST_PAYLOAD = 2'(PAYLOAD_LEN - 1);

`ifdef PONG_RX_CHECKSUM_EN
  typedef enum logic [1:0] {
    F_HUNT  = 2'd0,
    F_BODY  = 2'd1,
    F_CHECK = 2'd2
  } frame_state_t;
`else
  typedef enum logic [1:0] {
    F_HUNT = 2'd0,
    F_BODY = 2'd1
  } frame_state_t;
`endif

  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            frame_err;

  frame_state_t    fstate, fstate_n;
  msg_type_t       msg_type;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            timed_out;
  logic            frame_ok;
  logic            deliver;
  logic [7:0]      pay1;
  logic [4:0]      pay2;
  logic [7:0]      pay3_now;
`ifdef PONG_RX_CHECKSUM_EN
  logic [7:0]      pay3;
  logic [7:0]      chk;
`endif

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_rx (
    .clock      (clock),
    .reset      (reset),
    .uart_rxd   (uart_rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign timed_out = (idle_cnt == TO_LAST);

  // Final payload byte: with a checksum it was stored before CHECK, otherwise
  // it is the byte completing the frame right now.
`ifdef PONG_RX_CHECKSUM_EN
  assign pay3_now = pay3;
`else
  assign pay3_now = byte_data;
`endif

  // ---------------------------------------------------------------- frame FSM
  always_comb begin
    fstate_n = fstate;
    frame_ok = 1'b0;
    if (frame_err) begin
      fstate_n = F_HUNT;
    end else begin
      case (fstate)
        F_HUNT: begin
          if (byte_valid && is_header(byte_data)) fstate_n = F_BODY;
        end
        F_BODY: begin
          if (byte_valid) begin
            if (byte_cnt == LAST_PAYLOAD) begin
`ifdef PONG_RX_CHECKSUM_EN
              fstate_n = F_CHECK;
`else
              fstate_n = F_HUNT;
              frame_ok = 1'b1;
`endif
            end
          end else if (timed_out) begin
            fstate_n = F_HUNT;
          end
        end
`ifdef PONG_RX_CHECKSUM_EN
        F_CHECK: begin
          if (byte_valid) begin
            fstate_n = F_HUNT;
            frame_ok = (byte_data == chk);
          end else if (timed_out) begin
            fstate_n = F_HUNT;
          end
        end
`endif
        default: fstate_n = F_HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fstate   <= F_HUNT;
      msg_type <= MSG_BALL;
      byte_cnt <= '0;
      idle_cnt <= '0;
      pay1     <= '0;
      pay2     <= '0;
`ifdef PONG_RX_CHECKSUM_EN
      pay3     <= '0;
      chk      <= '0;
`endif
    end else begin
      fstate <= fstate_n;

      // Inter-byte gap counter; only meaningful once a header is accepted.
      if (byte_valid || fstate == F_HUNT) begin
        idle_cnt <= '0;
      end else if (!timed_out) begin
        idle_cnt <= idle_cnt + TO_ONE;
      end

      if (fstate == F_HUNT && byte_valid && is_header(byte_data)) begin
        msg_type <= header_type(byte_data);
        byte_cnt <= '0;
`ifdef PONG_RX_CHECKSUM_EN
        chk      <= byte_data;
`endif
      end

      if (fstate == F_BODY && byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef PONG_RX_CHECKSUM_EN
        chk      <= chk ^ byte_data;
`endif
        case (byte_cnt)
          2'd0:    pay1 <= byte_data;
          2'd1:    pay2 <= byte_data[SCORE_W-1:0];
`ifdef PONG_RX_CHECKSUM_EN
          default: pay3 <= byte_data;
`else
          default: ;
`endif
        endcase
      end
    end
  end

  // ----------------------------------------------------------- message output
  // An ack on the completion edge frees the slot, so the new frame is
  // delivered instead of counted as an overrun.
  assign deliver = frame_ok && (!new_message_received || message_acked);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      new_message_received    <= 1'b0;
      ball_message_rx         <= 1'b0;
      miss_message_rx         <= 1'b0;
      new_game_message_rx     <= 1'b0;
      new_game_ack_message_rx <= 1'b0;
      ball_y_rx               <= '0;
      velocity_x_rx           <= '0;
      velocity_y_rx           <= '0;
      my_score_rx             <= '0;
      your_score_rx           <= '0;
      you_should_serve_rx     <= 1'b0;
      you_serve_first_rx      <= 1'b0;
      overrun                 <= 1'b0;
    end else begin
      if (deliver) begin
        new_message_received    <= 1'b1;
        ball_message_rx         <= (msg_type == MSG_BALL);
        miss_message_rx         <= (msg_type == MSG_MISS);
        new_game_message_rx     <= (msg_type == MSG_NEW_GAME);
        new_game_ack_message_rx <= (msg_type == MSG_ACK);
        // Only the fields owned by the decoded type are refreshed.
        case (msg_type)
          MSG_BALL: begin
            ball_y_rx     <= {pay2[BALL_Y_HI_BIT], pay1};
            velocity_x_rx <= pay3_now[VEL_X_LSB +: VEL_W];
            velocity_y_rx <= pay3_now[VEL_Y_LSB +: VEL_W];
          end
          MSG_MISS: begin
            my_score_rx         <= pay1[SCORE_W-1:0];
            your_score_rx       <= pay2;
            you_should_serve_rx <= pay3_now[SERVE_BIT];
          end
          MSG_NEW_GAME: begin
            you_serve_first_rx <= pay1[SERVE_BIT];
          end
          default: ;
        endcase
      end else begin
        if (frame_ok) begin
          overrun <= 1'b1;
        end
        if (message_acked) begin
          new_message_received    <= 1'b0;
          ball_message_rx         <= 1'b0;
          miss_message_rx         <= 1'b0;
          new_game_message_rx     <= 1'b0;
          new_game_ack_message_rx <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_msg_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_msg_rx
// Description : Self-checking bench for pong_msg_rx. Frames are driven on the
//               serial line at 10 clocks per bit; each frame expected to be
//               delivered pushes the anticipated output state onto a queue,
//               and a monitor pops and compares it when a delivery appears.
//               Honours PONG_RX_CHECKSUM_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_msg_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;

  typedef struct packed {
    logic       ball;
    logic       miss;
    logic       ng;
    logic       ack;
    logic [8:0] y;
    logic [3:0] vx;
    logic [3:0] vy;
    logic [4:0] my;
    logic [4:0] your;
    logic       serve;
    logic       first;
  } msg_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       message_acked = 1'b0;
  logic       new_message_received;
  logic       ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx;
  logic [8:0] ball_y_rx;
  logic [3:0] velocity_x_rx, velocity_y_rx;
  logic [4:0] my_score_rx, your_score_rx;
  logic       you_should_serve_rx, you_serve_first_rx;
  logic       overrun;

  int   total = 0;
  int   bad   = 0;
  msg_t model = '0;
  msg_t exp_q[$];
  logic nmr_prev = 1'b0;
  logic ack_at_edge = 1'b0;

  pong_msg_rx #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (20)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .uart_rxd                (uart_rxd),
    .message_acked           (message_acked),
    .new_message_received    (new_message_received),
    .ball_message_rx         (ball_message_rx),
    .miss_message_rx         (miss_message_rx),
    .new_game_message_rx     (new_game_message_rx),
    .new_game_ack_message_rx (new_game_ack_message_rx),
    .ball_y_rx               (ball_y_rx),
    .velocity_x_rx           (velocity_x_rx),
    .velocity_y_rx           (velocity_y_rx),
    .my_score_rx             (my_score_rx),
    .your_score_rx           (your_score_rx),
    .you_should_serve_rx     (you_should_serve_rx),
    .you_serve_first_rx      (you_serve_first_rx),
    .overrun                 (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic msg_t obs_msg();
    msg_t m;
    m.ball  = ball_message_rx;
    m.miss  = miss_message_rx;
    m.ng    = new_game_message_rx;
    m.ack   = new_game_ack_message_rx;
    m.y     = ball_y_rx;
    m.vx    = velocity_x_rx;
    m.vy    = velocity_y_rx;
    m.my    = my_score_rx;
    m.your  = your_score_rx;
    m.serve = you_should_serve_rx;
    m.first = you_serve_first_rx;
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode of a frame into the expected output state.
  task automatic expect_frame(input logic [7:0] h, b1, b2, b3);
    model.ball = (h[3:2] == 2'd0);
    model.miss = (h[3:2] == 2'd1);
    model.ng   = (h[3:2] == 2'd2);
    model.ack  = (h[3:2] == 2'd3);
    case (h[3:2])
      2'd0: begin model.y = {b2[0], b1}; model.vx = b3[7:4]; model.vy = b3[3:0]; end
      2'd1: begin model.my = b1[4:0]; model.your = b2[4:0]; model.serve = b3[0]; end
      2'd2: model.first = b1[0];
      default: ;
    endcase
    exp_q.push_back(model);
  endtask

  // One 8N1 byte, starting at a falling clock edge. With ack_on_edge the
  // ack pulse lands on the edge where the frame layer sees this byte.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit ack_on_edge);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rxd = stop_bit;
    if (ack_on_edge) begin
      repeat (CPB - 2) @(negedge clock);
      message_acked = 1'b1;
      @(negedge clock);
      message_acked = 1'b0;
      @(negedge clock);
    end else begin
      repeat (CPB) @(negedge clock);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] h, b1, b2, b3, input bit ack_last);
    send_byte(h, 1'b1, 1'b0);
    send_byte(b1, 1'b1, 1'b0);
    send_byte(b2, 1'b1, 1'b0);
`ifdef PONG_RX_CHECKSUM_EN
    send_byte(b3, 1'b1, 1'b0);
    send_byte(h ^ b1 ^ b2 ^ b3, 1'b1, ack_last);
`else
    send_byte(b3, 1'b1, ack_last);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic do_ack(input string tag);
    message_acked = 1'b1;
    @(negedge clock);
    message_acked = 1'b0;
    model.ball = 1'b0;
    model.miss = 1'b0;
    model.ng   = 1'b0;
    model.ack  = 1'b0;
    check({tag, "_ack_nmr"}, new_message_received, 0);
    check({tag, "_ack_hold"}, obs_msg(), model);
  endtask

  always @(posedge clock) ack_at_edge <= message_acked;

  // Delivery = nmr rising, or nmr staying high across an edge that carried an ack.
  always @(negedge clock) begin
    if (!reset && new_message_received && (!nmr_prev || ack_at_edge)) begin
      check("delivery_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("delivery", obs_msg(), exp_q.pop_front());
    end
    nmr_prev = new_message_received;
  end

  initial begin
    reset = 1'b1;
    idle(5);
    check("reset_fields", obs_msg(), 0);
    check("reset_nmr", new_message_received, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;
    idle(3);

    // Ball frame, then ack
    expect_frame(8'hA0, 8'h2C, 8'h01, 8'h3E);
    send_frame(8'hA0, 8'h2C, 8'h01, 8'h3E, 1'b0);
    wait_drain("ball_drain");
    check("ball_nmr", new_message_received, 1);
    check("ball_y", ball_y_rx, 9'h12C);
    check("ball_vy", velocity_y_rx, 4'hE);
    do_ack("ball");
    idle(20);

    // Miss frame; ball fields must survive
    expect_frame(8'hA4, 8'h07, 8'h0B, 8'h01);
    send_frame(8'hA4, 8'h07, 8'h0B, 8'h01, 1'b0);
    wait_drain("miss_drain");
    check("miss_scores", {my_score_rx, your_score_rx, you_should_serve_rx}, {5'd7, 5'd11, 1'b1});
    do_ack("miss");
    idle(20);

    // Overrun: second frame while pending is dropped
    expect_frame(8'hA0, 8'h10, 8'h00, 8'h52);
    send_frame(8'hA0, 8'h10, 8'h00, 8'h52, 1'b0);
    wait_drain("ovr_first_drain");
    send_frame(8'hA0, 8'hFF, 8'h01, 8'h71, 1'b0);
    idle(5);
    check("ovr_flag", overrun, 1);
    check("ovr_nmr", new_message_received, 1);
    check("ovr_hold", obs_msg(), model);
    // Third frame completes on the same edge as the ack
    expect_frame(8'hA0, 8'h33, 8'h01, 8'h9F);
    send_frame(8'hA0, 8'h33, 8'h01, 8'h9F, 1'b1);
    wait_drain("same_edge_drain");
    check("same_edge_nmr", new_message_received, 1);
    check("same_edge_overrun", overrun, 1);
    do_ack("third");
    check("overrun_sticky", overrun, 1);
    idle(20);

    // Garbage, header, framing error, then a good new-game frame
    send_byte(8'h55, 1'b1, 1'b0);
    send_byte(8'hA8, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    idle(30);
    check("framing_no_msg", new_message_received, 0);
    expect_frame(8'hA8, 8'h01, 8'h00, 8'h00);
    send_frame(8'hA8, 8'h01, 8'h00, 8'h00, 1'b0);
    wait_drain("ng_drain");
    check("ng_first", you_serve_first_rx, 1);
    do_ack("ng");
    idle(20);

    // Inter-byte timeout returns to HUNT
    send_byte(8'hA0, 1'b1, 1'b0);
    idle(250);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    idle(30);
    check("timeout_no_msg", new_message_received, 0);
    check("timeout_hold", obs_msg(), model);

    // Header with nonzero low bits is not a header
    send_frame(8'hA2, 8'h2C, 8'h01, 8'h3E, 1'b0);
    idle(30);
    check("badhdr_no_msg", new_message_received, 0);

    // Ack-type frame: only the flag changes
    expect_frame(8'hAC, 8'h00, 8'h00, 8'h00);
    send_frame(8'hAC, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_drain("ackmsg_drain");
    do_ack("ackmsg");
    idle(20);

`ifdef PONG_RX_CHECKSUM_EN
    expect_frame(8'hA0, 8'h00, 8'h00, 8'h00);
    send_frame(8'hA0, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_drain("chk_good_drain");
    do_ack("chk_good");
    idle(20);
    send_byte(8'hA0, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hA1, 1'b1, 1'b0);
    idle(30);
    check("chk_bad_no_msg", new_message_received, 0);
    check("chk_bad_overrun", overrun, 1);
    idle(20);
`endif

    // Reset mid-frame while a message is pending
    expect_frame(8'hA4, 8'h03, 8'h04, 8'h00);
    send_frame(8'hA4, 8'h03, 8'h04, 8'h00, 1'b0);
    wait_drain("pre_reset_drain");
    send_byte(8'hA8, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    reset = 1'b1;
    idle(3);
    model = '0;
    check("midreset_fields", obs_msg(), 0);
    check("midreset_nmr", new_message_received, 0);
    check("midreset_overrun", overrun, 0);
    reset = 1'b0;
    idle(3);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
`ifdef PONG_RX_CHECKSUM_EN
    send_byte(8'hA9, 1'b1, 1'b0);
`endif
    idle(30);
    check("partial_discarded", new_message_received, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
